life_stepper: RTL
=================

// Module: life_stepper
// PURPOSE
//  Parametrised generation engine for the game-of-life core. On a start pulse it
//  sweeps a BOARD_W x BOARD_H one-bit cell buffer and writes the next generation
//  to a second buffer. Rules are runtime-selectable birth/survive masks, so it
//  covers any outer-totalistic rule, not just B3/S23. Edges are a dead border or
//  a torus. Sits between the seeder/frame buffers and the render path.
// PARAMETERS
//  BOARD_W  64  board width in cells (>=3)
//  BOARD_H  48  board height in cells (>=3)
//  WRAP     0   0: cells outside the board read as dead; 1: toroidal wrap
//  AW       $clog2(BOARD_W*BOARD_H)  cell address width (derived, not overridden)
// PORTS
//  clk_in         in   1   system clock (clk_25mhz domain)
//  rst_in         in   1   synchronous, active-high reset
//  start_in       in   1   one-cycle pulse: begin a generation
//  birth_in       in   9   bit n set: a dead cell with n live neighbours is born
//  survive_in     in   9   bit n set: a live cell with n live neighbours survives
//  rd_en_out      out  1   read strobe to the current-generation buffer
//  rd_addr_out    out  AW  read address, y*BOARD_W + x
//  rd_data_in     in   1   cell value, valid exactly 1 cycle after rd_en_out
//  wr_en_out      out  1   write strobe to the next-generation buffer
//  wr_addr_out    out  AW  write address, y*BOARD_W + x
//  wr_data_out    out  1   next-generation cell value
//  busy_out       out  1   high from the accepted start until done
//  done_out       out  1   one-cycle pulse after the last write
//  pop_out        out  AW+1  live cells written in the last completed generation
//  gen_count_out  out  16  completed generations; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: FSM=IDLE. All outputs 0, including gen_count_out and pop_out.
//   Reset mid-sweep: no write in the following cycle; the sweep is abandoned.
//  FSM states: IDLE -> PRIME -> SWEEP -> FLUSH -> IDLE.
//   IDLE: start_in accepted. birth_in/survive_in latched; busy_out=1 next cycle.
//   start_in while busy is ignored. Rule inputs are ignored outside acceptance.
//   PRIME (per row y): fetch columns x=-1 and x=0 into a 3x3 window; 6 cycles.
//   SWEEP: for cx=1..BOARD_W, fetch column cx in row order y-1, y, y+1, one
//    read slot per cycle (3 cycles per column).
//    When column cx's last datum returns, the window holds cx-2..cx.
//    Cell (cx-1,y) is then evaluated and written in that same cycle.
//    After cx=BOARD_W: advance to row y+1 (PRIME), or FLUSH after row BOARD_H-1.
//   FLUSH: waits for the last write. Then done_out=1 for 1 cycle,
//    busy_out=0, gen_count_out+1, pop_out updated. Back to IDLE.
//  Out-of-range coordinates (x=-1, x=BOARD_W, y=-1, y=BOARD_H):
//   WRAP=0: slot consumed, rd_en_out=0, datum forced to 0.
//   WRAP=1: coordinate taken mod board size and actually read.
//   Slot timing is identical in both modes.
//  Latency: start accepted at cycle 0 -> done_out high at cycle
//   3*BOARD_H*(BOARD_W+2)+2. Writes strictly row-major, exactly BOARD_W*BOARD_H.
//  Rule: n = the 8 neighbours summed (4-bit).
//   next = alive ? survive_r[n] : birth_r[n]. Centre cell excluded from n.
//  Population accumulates in an internal AW+1-bit counter cleared at start.
//   pop_out changes only at done.
//  rd and wr address arithmetic never exceeds BOARD_W*BOARD_H-1.
// TESTING
//  1 8x8 WRAP=0 B3/S23, blinker (3,2),(3,3),(3,4) -> writes live only at
//    (2,3),(3,3),(4,3). pop_out=3; done_out at cycle 242.
//  2 8x8 WRAP=1 B3/S23, cells (0,0),(7,0),(0,7) -> (7,7) born; pop_out=4.
//    Same seed with WRAP=0 -> pop_out=0, rd_en_out never high for out-of-range slots.
//  3 8x8 WRAP=0 birth=9'h002 survive=0, single cell (4,4) -> its 8 neighbours
//    live, (4,4) dead, pop_out=8.
//  4 8x8 WRAP=1 all-ones board, B3/S23 -> all 64 writes are 0; pop_out=0;
//    gen_count_out 0->1.
//  5 Second start_in pulse at cycle 50 of a sweep -> ignored. Exactly 64 writes,
//    one done_out, gen_count_out=1.
//  6 rst_in at cycle 100 -> wr_en_out=0 from cycle 101. busy_out=0,
//    gen_count_out=0; a fresh start then completes normally.

Source files
------------

// File: rtl/life_stepper.sv
// Game-of-life generation engine: sweeps the current-generation buffer through a
// 3x3 column window and writes the next generation using runtime birth/survive masks.
module life_stepper #(
    parameter int  BOARD_W = 64,
    parameter int  BOARD_H = 48,
    parameter bit  WRAP    = 1'b0,
    localparam int AW      = $clog2(BOARD_W * BOARD_H)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic [8:0]    birth_in,
    input  logic [8:0]    survive_in,
    output logic          rd_en_out,
    output logic [AW-1:0] rd_addr_out,
    input  logic          rd_data_in,
    output logic          wr_en_out,
    output logic [AW-1:0] wr_addr_out,
    output logic          wr_data_out,
    output logic          busy_out,
    output logic          done_out,
    output logic [AW:0]   pop_out,
    output logic [15:0]   gen_count_out
);

    localparam int XW = $clog2(BOARD_W + 2);
    localparam int YW = $clog2(BOARD_H);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SWEEP, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XW-1:0]   r_k;          // window column slot; board x = r_k - 1
    logic [1:0]      r_r;          // row slot within a column: y-1, y, y+1
    logic [YW-1:0]   r_y;
    logic [8:0]      r_birth;
    logic [8:0]      r_survive;
    logic            r_d_vld;
    logic [1:0]      r_d_row;
    logic            r_d_wr;
    logic            r_d_zero;
    logic [1:0]      r_cur;
    logic [2:0]      r_col_a;
    logic [2:0]      r_col_b;
    logic [AW-1:0]   r_wr_addr;
    logic [AW:0]     r_pop_acc;
    logic [AW:0]     r_pop;
    logic [15:0]     r_gen;
    logic            r_done;

    logic            w_slot;
    logic            w_col_end;
    logic            w_x_lo;
    logic            w_x_hi;
    logic            w_last_row;
    logic            w_oob;
    logic [XW-1:0]   w_rx;
    logic [YW-1:0]   w_ry;
    logic [AW-1:0]   w_rd_addr;
    logic            w_datum;
    logic [2:0]      w_col_new;
    logic [3:0]      w_n;
    logic            w_next;
    logic            w_wr_en;
    logic [AW:0]     w_pop_next;

    // Read-slot coordinates, with out-of-board slots folded back onto the torus.
    always_comb begin
        w_slot     = (r_state == S_PRIME) || (r_state == S_SWEEP);
        w_col_end  = (r_r == 2'd2);
        w_x_lo     = (r_k == '0);
        w_x_hi     = (r_k == XW'(BOARD_W + 1));
        w_last_row = (r_y == YW'(BOARD_H - 1));
        w_oob      = w_x_lo || w_x_hi || ((r_y == '0) && (r_r == 2'd0)) ||
                     (w_last_row && w_col_end);
        if (w_x_lo)      w_rx = XW'(BOARD_W - 1);
        else if (w_x_hi) w_rx = '0;
        else             w_rx = r_k - XW'(1);
        case (r_r)
            2'd0:    w_ry = (r_y == '0) ? YW'(BOARD_H - 1) : r_y - YW'(1);
            2'd1:    w_ry = r_y;
            default: w_ry = w_last_row ? '0 : r_y + YW'(1);
        endcase
        w_rd_addr = AW'(w_ry) * AW'(BOARD_W) + AW'(w_rx);
    end

    // Evaluate the centre column cell as the last datum of the leading column arrives.
    always_comb begin
        w_datum    = r_d_zero ? 1'b0 : rd_data_in;
        w_col_new  = {w_datum, r_cur[1], r_cur[0]};
        w_n        = 4'(r_col_a[0]) + 4'(r_col_a[1]) + 4'(r_col_a[2]) +
                     4'(r_col_b[0]) + 4'(r_col_b[2]) +
                     4'(w_col_new[0]) + 4'(w_col_new[1]) + 4'(w_col_new[2]);
        w_next     = r_col_b[1] ? r_survive[w_n] : r_birth[w_n];
        w_wr_en    = r_d_vld && r_d_wr;
        w_pop_next = r_pop_acc + (AW + 1)'(w_wr_en && w_next);
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        rd_en_out   = 1'b0;
        rd_addr_out = '0;
        case (r_state)
            S_IDLE:  if (start_in) w_state_nxt = S_PRIME;
            S_PRIME: if (w_col_end && (r_k == XW'(1))) w_state_nxt = S_SWEEP;
            S_SWEEP: if (w_col_end && w_x_hi) w_state_nxt = w_last_row ? S_FLUSH : S_PRIME;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_slot && (WRAP || !w_oob)) begin
            rd_en_out   = 1'b1;
            rd_addr_out = w_rd_addr;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_r       <= '0;
            r_y       <= '0;
            r_birth   <= '0;
            r_survive <= '0;
            r_d_vld   <= 1'b0;
            r_d_row   <= '0;
            r_d_wr    <= 1'b0;
            r_d_zero  <= 1'b0;
            r_cur     <= '0;
            r_col_a   <= '0;
            r_col_b   <= '0;
            r_wr_addr <= '0;
            r_pop_acc <= '0;
            r_pop     <= '0;
            r_gen     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_d_vld  <= w_slot;
            r_d_row  <= r_r;
            r_d_wr   <= (r_state == S_SWEEP) && w_col_end;
            r_d_zero <= !WRAP && w_oob;
            r_done   <= (r_state == S_FLUSH);

            if ((r_state == S_IDLE) && start_in) begin
                r_k       <= '0;
                r_r       <= '0;
                r_y       <= '0;
                r_birth   <= birth_in;
                r_survive <= survive_in;
                r_wr_addr <= '0;
                r_pop_acc <= '0;
            end else if (w_slot) begin
                r_r <= w_col_end ? 2'd0 : r_r + 2'd1;
                if (w_col_end) begin
                    if (w_x_hi) begin
                        r_k <= '0;
                        if (!w_last_row) r_y <= r_y + YW'(1);
                    end else begin
                        r_k <= r_k + XW'(1);
                    end
                end
            end

            if (r_d_vld) begin
                case (r_d_row)
                    2'd0:    r_cur[0] <= w_datum;
                    2'd1:    r_cur[1] <= w_datum;
                    default: begin
                        r_col_a <= r_col_b;
                        r_col_b <= w_col_new;
                    end
                endcase
            end

            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + AW'(1);
                r_pop_acc <= w_pop_next;
            end

            if (r_state == S_FLUSH) begin
                r_pop <= w_pop_next;
                r_gen <= r_gen + 16'd1;
            end
        end
    end

    assign wr_en_out     = w_wr_en;
    assign wr_addr_out   = w_wr_en ? r_wr_addr : '0;
    assign wr_data_out   = w_wr_en && w_next;
    assign busy_out      = (r_state != S_IDLE);
    assign done_out      = r_done;
    assign pop_out       = r_pop;
    assign gen_count_out = r_gen;

endmodule
